// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Each cycle at most one request is accepted by round-robin arbitration. The
// accepted operation is held in a single-entry issue register that drives the
// ALU operand and control outputs. The ALU result returns to the owning
// requester over a valid/ready response channel one cycle after acceptance.
// A response consumed in the same cycle as a new accept gives one op/cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_ra, reqN_rb      operands
//   reqN_arith_mode       0 add, 1 subtract
//   reqN_logic_alt        logic/shift alternate select
//   reqN_funct3           logic/shift function
//   reqN_sel              result select: 0 arith_out, 1 logic_out
//   rspN_valid/ready      response handshake for requester N
//   rspN_data             selected ALU result (same value on both ports)
//   alu_*                 registered ALU inputs / combinational ALU results
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_ra,
  input  logic [WIDTH-1:0] req0_rb,
  input  logic             req0_arith_mode,
  input  logic             req0_logic_alt,
  input  logic [2:0]       req0_funct3,
  input  logic             req0_sel,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_ra,
  input  logic [WIDTH-1:0] req1_rb,
  input  logic             req1_arith_mode,
  input  logic             req1_logic_alt,
  input  logic [2:0]       req1_funct3,
  input  logic             req1_sel,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,

  output logic [WIDTH-1:0] alu_ra,
  output logic [WIDTH-1:0] alu_rb,
  output logic             alu_arith_mode,
  output logic             alu_logic_alt,
  output logic [2:0]       alu_funct3,
  input  logic [WIDTH-1:0] alu_arith_out,
  input  logic [WIDTH-1:0] alu_logic_out
);

  // Issue register
  logic             op_valid_q,   op_valid_d;
  logic             owner_q,      owner_d;
  logic             sel_q,        sel_d;
  logic [WIDTH-1:0] ra_q,         ra_d;
  logic [WIDTH-1:0] rb_q,         rb_d;
  logic             arith_mode_q, arith_mode_d;
  logic             logic_alt_q,  logic_alt_d;
  logic [2:0]       funct3_q,     funct3_d;
  // Round-robin pointer: port most recently accepted
  logic             last_grant_q, last_grant_d;

  logic             rsp_fire;
  logic             slot_free;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] result;

  // Grant depends only on the valids; ready only on grant and slot_free, so
  // there is no valid->ready->valid loop on a port.
  always_comb begin
    rsp_fire   = op_valid_q && (owner_q ? rsp1_ready : rsp0_ready);
    slot_free  = !op_valid_q || rsp_fire;
    grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    // Requests are ignored while rst is asserted.
    req0_ready = slot_free && !rst && !grant;
    req1_ready = slot_free && !rst && grant;
    accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  end

  always_comb begin
    op_valid_d   = op_valid_q;
    owner_d      = owner_q;
    sel_d        = sel_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    arith_mode_d = arith_mode_q;
    logic_alt_d  = logic_alt_q;
    funct3_d     = funct3_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      op_valid_d   = 1'b1;
      owner_d      = grant;
      last_grant_d = grant;
      sel_d        = grant ? req1_sel        : req0_sel;
      ra_d         = grant ? req1_ra         : req0_ra;
      rb_d         = grant ? req1_rb         : req0_rb;
      arith_mode_d = grant ? req1_arith_mode : req0_arith_mode;
      logic_alt_d  = grant ? req1_logic_alt  : req0_logic_alt;
      funct3_d     = grant ? req1_funct3     : req0_funct3;
    end else if (rsp_fire) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q   <= 1'b0;
      owner_q      <= 1'b0;
      sel_q        <= 1'b0;
      ra_q         <= '0;
      rb_q         <= '0;
      arith_mode_q <= 1'b0;
      logic_alt_q  <= 1'b0;
      funct3_q     <= 3'd0;
      last_grant_q <= 1'b1;  // port 0 wins the first contention
    end else begin
      op_valid_q   <= op_valid_d;
      owner_q      <= owner_d;
      sel_q        <= sel_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      arith_mode_q <= arith_mode_d;
      logic_alt_q  <= logic_alt_d;
      funct3_q     <= funct3_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    alu_ra         = ra_q;
    alu_rb         = rb_q;
    alu_arith_mode = arith_mode_q;
    alu_logic_alt  = logic_alt_q;
    alu_funct3     = funct3_q;
    result         = sel_q ? alu_logic_out : alu_arith_out;
    // A pending response is dropped, not emitted, while rst is asserted.
    rsp0_valid     = op_valid_q && !owner_q && !rst;
    rsp1_valid     = op_valid_q && owner_q && !rst;
    rsp0_data      = result;
    rsp1_data      = result;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_arith_mode, req0_logic_alt, req0_sel;
  logic         req1_valid, req1_ready, req1_arith_mode, req1_logic_alt, req1_sel;
  logic [W-1:0] req0_ra, req0_rb, req1_ra, req1_rb;
  logic [2:0]   req0_funct3, req1_funct3;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic [W-1:0] alu_ra, alu_rb, alu_arith_out, alu_logic_out;
  logic         alu_arith_mode, alu_logic_alt;
  logic [2:0]   alu_funct3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in combinational ALU
  always_comb begin
    alu_arith_out = alu_arith_mode ? (alu_ra - alu_rb) : (alu_ra + alu_rb);
    case (alu_funct3)
      3'b100:  alu_logic_out = alu_ra ^ alu_rb;
      3'b110:  alu_logic_out = alu_ra | alu_rb;
      3'b111:  alu_logic_out = alu_ra & alu_rb;
      default: alu_logic_out = alu_ra;
    endcase
  end

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ra(req0_ra), .req0_rb(req0_rb),
    .req0_arith_mode(req0_arith_mode), .req0_logic_alt(req0_logic_alt),
    .req0_funct3(req0_funct3), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ra(req1_ra), .req1_rb(req1_rb),
    .req1_arith_mode(req1_arith_mode), .req1_logic_alt(req1_logic_alt),
    .req1_funct3(req1_funct3), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_arith_mode(alu_arith_mode),
    .alu_logic_alt(alu_logic_alt), .alu_funct3(alu_funct3),
    .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_ra = '0; req0_rb = '0; req0_arith_mode = 1'b0;
    req0_logic_alt = 1'b0; req0_funct3 = 3'd0; req0_sel = 1'b0;
    req1_valid = 1'b1; req1_ra = '0; req1_rb = '0; req1_arith_mode = 1'b0;
    req1_logic_alt = 1'b0; req1_funct3 = 3'd0; req1_sel = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state, with both requests asserted during rst
    cyc();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_ra", alu_ra, 0);
    check("rst_alu_funct3", alu_funct3, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    // Single op: 5 + 7
    req0_valid = 1'b1; req0_ra = 5; req0_rb = 7; req0_arith_mode = 1'b0; req0_sel = 1'b0;
    #1;
    check("single_req0_ready", req0_ready, 1);
    check("single_req1_ready", req1_ready, 0);
    cyc();
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    #1;
    check("single_rsp0_valid", rsp0_valid, 1);
    check("single_rsp0_data", rsp0_data, 12);
    check("single_rsp1_valid", rsp1_valid, 0);
    check("single_alu_ra", alu_ra, 5);
    cyc();
    check("single_drained", rsp0_valid, 0);

    // Contention: port 0 computes 10-3, port 1 computes 0xFF & 0xF0
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_ra = 10; req0_rb = 3; req0_arith_mode = 1'b1; req0_sel = 1'b0;
    req1_valid = 1'b1; req1_ra = 32'hFF; req1_rb = 32'hF0; req1_funct3 = 3'b111;
    req1_sel = 1'b1;
    #1;
    check("cont_g0_req0_ready", req0_ready, 1);
    check("cont_g0_req1_ready", req1_ready, 0);
    cyc();
    check("cont_rsp0_valid", rsp0_valid, 1);
    check("cont_rsp0_data", rsp0_data, 7);
    check("cont_g1_req1_ready", req1_ready, 1);
    check("cont_g1_req0_ready", req0_ready, 0);
    cyc();
    check("cont_rsp1_valid", rsp1_valid, 1);
    check("cont_rsp1_data", rsp1_data, 32'hF0);
    check("cont_rsp0_idle", rsp0_valid, 0);
    check("cont_g2_req0_ready", req0_ready, 1);
    cyc();
    check("cont_g3_req1_ready", req1_ready, 1);
    check("cont_g3_rsp0_data", rsp0_data, 7);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    cyc();

    // Back-pressure on port 1 while port 0 waits
    do_reset();
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    req1_valid = 1'b1; req1_ra = 20; req1_rb = 22; req1_arith_mode = 1'b0; req1_sel = 1'b0;
    #1;
    check("bp_req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_ra = 100; req0_rb = 1; req0_arith_mode = 1'b0; req0_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_rsp1_data", rsp1_data, 42);
      check("bp_alu_ra", alu_ra, 20);
      check("bp_alu_rb", alu_rb, 22);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_req1_ready", req1_ready, 0);
      cyc();
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp_release_req0_ready", req0_ready, 1);
    check("bp_release_rsp1_data", rsp1_data, 42);
    cyc();
    check("bp_next_rsp0_valid", rsp0_valid, 1);
    check("bp_next_rsp0_data", rsp0_data, 101);
    check("bp_next_rsp1_valid", rsp1_valid, 0);
    req0_valid = 1'b0;
    cyc();

    // Streaming: ra = 1..8, rb = 1
    rsp0_ready = 1'b1;
    req0_valid = 1'b1; req0_rb = 1;
    for (int i = 1; i <= 8; i++) begin
      req0_ra = W'(i);
      #1;
      check("stream_req0_ready", req0_ready, 1);
      if (i > 1) begin
        check("stream_rsp0_valid", rsp0_valid, 1);
        check("stream_rsp0_data", rsp0_data, W'(i));
      end
      cyc();
    end
    req0_valid = 1'b0;
    #1;
    check("stream_last_valid", rsp0_valid, 1);
    check("stream_last_data", rsp0_data, 9);
    cyc();
    check("stream_drained", rsp0_valid, 0);

    // Reset mid-op: pending port 1 response must be dropped
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_ra = 3; req1_rb = 4; req1_sel = 1'b0; req1_arith_mode = 1'b0;
    #1;
    check("rmo_req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 1'b0; rst = 1'b1;
    #1;
    check("rmo_rst_rsp1_valid", rsp1_valid, 0);
    cyc();
    rst = 1'b0; rsp1_ready = 1'b1;
    #1;
    check("rmo_after_rsp1_valid", rsp1_valid, 0);
    req0_valid = 1'b1; req0_ra = 1; req0_rb = 1; req0_arith_mode = 1'b0; req0_sel = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("rmo_cont_req0_ready", req0_ready, 1);
    check("rmo_cont_req1_ready", req1_ready, 0);
    cyc();
    check("rmo_rsp0_data", rsp0_data, 2);
    check("rmo_rsp1_never", rsp1_valid, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    cyc();

    // Fairness: req1 always valid, req0 pulses every third cycle
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req0_valid = ((k % 3) == 0);
      #1;
      check("fair_req0_ready", req0_ready, W'((k % 3) == 0));
      check("fair_req1_ready", req1_ready, W'((k % 3) != 0));
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters, e.g. the execute stage (port 0) and an address/branch helper unit (port 1). It accepts one operation per cycle using round-robin arbitration and holds it in a single-entry issue register that drives the ALU operand inputs. It returns the selected ALU result to the owning requester over a valid/ready response channel. Result latency is one cycle, with full back-pressure.

## Interface
- WIDTH, 32, datapath width; must equal the connected ALU's WIDTH.

Ports (N ∈ {0,1}: two identical requester ports):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- reqN_valid  in  1  requester N presents an operation
- reqN_ready  out  1  arbiter accepts requester N this cycle
- reqN_ra  in  WIDTH  operand A
- reqN_rb  in  WIDTH  operand B
- reqN_arith_mode  in  1  ALU arithmetic mode (0 add, 1 subtract)
- reqN_logic_alt  in  1  ALU logic/shift alternate select
- reqN_funct3  in  3  ALU logic/shift function
- reqN_sel  in  1  result select: 0 = arith_out, 1 = logic_out
- rspN_valid  out  1  result for requester N available
- rspN_ready  in  1  requester N consumes result
- rspN_data  out  WIDTH  result
- alu_ra, alu_rb  out  WIDTH  ALU operands (registered)
- alu_arith_mode, alu_logic_alt  out  1  ALU controls (registered)
- alu_funct3  out  3  ALU function (registered)
- alu_arith_out, alu_logic_out  in  WIDTH  ALU results (combinational return)

## Operation
- State: issue register {op_valid, owner, sel, ra, rb, arith_mode, logic_alt, funct3}; round-robin pointer last_grant (1 bit).
- Issue register drives the alu_* outputs directly. The ALU is combinational, so its results are valid in the same cycle.
- Response: rspN_valid = op_valid && owner==N. rspN_data = sel ? alu_logic_out : alu_arith_out, and is driven identically on both ports. Non-owner data is don't-care.
- rsp_fire = op_valid && rspN_ready for N = owner.
- Issue slot is free when !op_valid || rsp_fire.
- Grant, combinational, evaluated only when the slot is free:
  - Only one reqN_valid asserted: grant N.
  - Both asserted: grant the port ≠ last_grant.
  - reqN_ready = slot_free && grant==N. At most one ready is high per cycle.
  - reqN_ready does not depend on reqN_valid of the same port in a way that creates a loop. Grant uses valids only; ready uses grant and slot_free.
- On accept (reqN_valid && reqN_ready):
  - Load the issue register from port N.
  - Set op_valid=1, owner=N, last_grant=N.
- On rsp_fire without accept: op_valid=0.
- On rsp_fire with accept in the same cycle: load the new op. Throughput is one op/cycle.
- Requesters hold operands stable while valid && !ready. The arbiter does not lock a grant across cycles.
- Fairness: under continuous contention, grants alternate strictly. No port waits more than one accepted op of the other port.

## Timing
- Reset values: op_valid=0; owner=0; sel=0; last_grant=1, so port 0 wins the first contention. alu_ra, alu_rb, alu_arith_mode, alu_logic_alt and alu_funct3 are 0. rsp0_valid and rsp1_valid are 0. Both reqN_ready are 0 during the rst cycle.
- Latency: accept at edge E puts the result on rspN_data/rspN_valid in the cycle after E. Earliest consume is edge E+1.
- Stall: while the owner's rspN_ready=0, the following hold stable:
  - issue register, alu_* outputs, rspN_valid, rspN_data;
  - both reqN_ready=0.
- Simultaneous rsp_fire and a new accept to the same or the other port: the response is consumed and the new op loads at the same edge, with no bubble.
- Reset mid-operation: rst on any edge clears op_valid and drops any pending response without emitting it. last_grant returns to 1. Requests are ignored during rst cycles.
- No combinational path from reqN_* to rspN_*. A path from rspN_ready to reqN_ready is allowed (via slot_free).

## Test plan
- Single op: after reset, req0 ra=5 rb=7 arith_mode=0 sel=0 for one cycle. Required: req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp1_valid=0.
- Contention: req0 and req1 both valid from the first post-reset cycle, rsp ready held 1; req0 computes 10-3 (arith_mode=1), req1 computes 0xF0 via logic path, sel=1. Required: port 0 accepted first (rsp0_data=7), port 1 accepted next cycle. Grants then alternate 0,1,0,1 over 4 cycles.
- Back-pressure: accept req1 op, then hold rsp1_ready=0 for 3 cycles while req0_valid=1. Required: rsp1_valid and rsp1_data stable, alu_* outputs unchanged, req0_ready=0 for 3 cycles. req0 is accepted in the cycle rsp1_ready rises.
- Streaming: req0 valid continuously with ra=1..8, rb=1, rsp0_ready=1. Required: 8 responses (2..9) on 8 consecutive cycles, no bubbles.
- Reset mid-op: accept req1 op, assert rst on the next edge with rsp1_ready=0. Required: rsp1_valid=0 after the reset edge; no response ever emitted; a following contention grants port 0 first.
- Alternation fairness: req1 always valid; req0 pulses valid every third cycle. Required: each req0 request is accepted within one grant of being asserted.
